// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared types and constants for the AXI4-Lite slave register bank:
//   addr_t / data_t / strb_t / resp_t  - channel payload types
//   RESP_OKAY / RESP_SLVERR            - response encodings
//   wr_state_e / rd_state_e            - write and read FSM states
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef logic [AXI_ADDR_W-1:0] addr_t;
    typedef logic [AXI_DATA_W-1:0] data_t;
    typedef logic [AXI_STRB_W-1:0] strb_t;
    typedef logic [1:0]            resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'b00,
        W_HAVE_A = 2'b01,
        W_HAVE_D = 2'b10,
        W_RESP   = 2'b11
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi_lite_reg_bank.sv
// ---------------------------------------------------------------------------
// axi_lite_reg_bank
// NUM_REGS x DATA_WIDTH register storage with byte-strobe merge.
//   aclk, areset_n  - clock, synchronous active-low clear of all registers
//   we, widx        - write enable and register index
//   wdata, wstrb    - write data and per-byte lane enables
//   ridx -> rdata   - combinational read port
// ---------------------------------------------------------------------------
module axi_lite_reg_bank #(
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_REGS   = 16,
    localparam int IDX_W      = $clog2(NUM_REGS),
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_W-1:0]     wstrb,
    input  logic [IDX_W-1:0]      ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

    // Storage: clear on reset, otherwise update only the strobed byte lanes.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    regs_r[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read port sees the pre-write contents on a same-edge write.
    assign rdata = regs_r[ridx];

endmodule

// File: rtl/axi_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_regs
// AXI4-Lite slave register bank with independent read and write paths.
//   aclk, areset_n                      - clock, synchronous active-low reset
//   awaddr/awvalid/awready              - write address channel
//   wdata/wstrb/wvalid/wready           - write data channel
//   bresp/bvalid/bready                 - write response channel
//   araddr/arvalid/arready              - read address channel
//   rdata/rresp/rvalid/rready           - read data channel
// All outputs are registered. Optional macro AXI_LITE_SLAVE_ERR_EN: out-of-
// range accesses return SLVERR (writes dropped, reads return zero); without
// it addresses alias modulo the bank size and all responses are OKAY.
// ---------------------------------------------------------------------------
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int                    IDX_W      = $clog2(NUM_REGS);
    localparam int                    STRB_W     = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] BANK_BYTES = ADDR_WIDTH'(4 * NUM_REGS);

    // True when addr falls inside [BASE_ADDR, BASE_ADDR + 4*NUM_REGS).
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && (off < BANK_BYTES);
    endfunction

    wr_state_e             w_state_r, w_next_s;
    rd_state_e             r_state_r, r_next_s;
    logic                  awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
    resp_t                 bresp_r, rresp_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [ADDR_WIDTH-1:0] awaddr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [STRB_W-1:0]     wstrb_r;

    logic                  aw_hs_s, w_hs_s, ar_hs_s;
    logic                  commit_s, bank_we_s, wr_ok_s, rd_ok_s;
    logic [ADDR_WIDTH-1:0] commit_addr_s;
    logic [DATA_WIDTH-1:0] commit_data_s, bank_rdata_s, rd_data_s;
    logic [STRB_W-1:0]     commit_strb_s;
    logic [IDX_W-1:0]      widx_s, ridx_s;
    resp_t                 commit_resp_s, rd_resp_s;

    assign aw_hs_s = awvalid & awready_r;
    assign w_hs_s  = wvalid  & wready_r;
    assign ar_hs_s = arvalid & arready_r;

    // Write FSM next state; commit fires on the edge the later of AW/W lands,
    // taking address/data from the channel or from the held copy as needed.
    always_comb begin
        w_next_s      = w_state_r;
        commit_s      = 1'b0;
        commit_addr_s = awaddr;
        commit_data_s = wdata;
        commit_strb_s = wstrb;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    commit_s = 1'b1;
                    w_next_s = W_RESP;
                end else if (aw_hs_s) begin
                    w_next_s = W_HAVE_A;
                end else if (w_hs_s) begin
                    w_next_s = W_HAVE_D;
                end else begin
                    w_next_s = W_IDLE;
                end
            end
            W_HAVE_A: begin
                commit_addr_s = awaddr_r;
                if (w_hs_s) begin
                    commit_s = 1'b1;
                    w_next_s = W_RESP;
                end else begin
                    w_next_s = W_HAVE_A;
                end
            end
            W_HAVE_D: begin
                commit_data_s = wdata_r;
                commit_strb_s = wstrb_r;
                if (aw_hs_s) begin
                    commit_s = 1'b1;
                    w_next_s = W_RESP;
                end else begin
                    w_next_s = W_HAVE_D;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_next_s = W_IDLE;
                end else begin
                    w_next_s = W_RESP;
                end
            end
            default: begin
                w_next_s = W_IDLE;
            end
        endcase
    end

    // Read FSM next state.
    always_comb begin
        r_next_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_next_s = R_DATA;
                end else begin
                    r_next_s = R_IDLE;
                end
            end
            R_DATA: begin
                if (rready) begin
                    r_next_s = R_IDLE;
                end else begin
                    r_next_s = R_DATA;
                end
            end
            default: begin
                r_next_s = R_IDLE;
            end
        endcase
    end

    // Casting the full offset keeps only the low index bits, so without the
    // error option out-of-range addresses alias modulo the bank size.
    assign widx_s = IDX_W'((commit_addr_s - BASE_ADDR) >> 2'd2);
    assign ridx_s = IDX_W'((araddr - BASE_ADDR) >> 2'd2);

`ifdef AXI_LITE_SLAVE_ERR_EN
    assign wr_ok_s = addr_in_range(commit_addr_s);
    assign rd_ok_s = addr_in_range(araddr);
`else
    assign wr_ok_s = 1'b1;
    assign rd_ok_s = 1'b1;
`endif

    assign bank_we_s     = commit_s & wr_ok_s;
    assign commit_resp_s = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
    assign rd_resp_s     = rd_ok_s ? RESP_OKAY : RESP_SLVERR;
    assign rd_data_s     = rd_ok_s ? bank_rdata_s : '0;

    // Write path registers: state, registered readies/valid and held payload.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            awaddr_r  <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
        end else begin
            w_state_r <= w_next_s;
            awready_r <= (w_next_s == W_IDLE) || (w_next_s == W_HAVE_D);
            wready_r  <= (w_next_s == W_IDLE) || (w_next_s == W_HAVE_A);
            bvalid_r  <= (w_next_s == W_RESP);
            if (aw_hs_s) begin
                awaddr_r <= awaddr;
            end
            if (w_hs_s) begin
                wdata_r <= wdata;
                wstrb_r <= wstrb;
            end
            if (commit_s) begin
                bresp_r <= commit_resp_s;
            end
        end
    end

    // Read path registers: data/response captured only at the AR handshake.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            rresp_r   <= RESP_OKAY;
        end else begin
            r_state_r <= r_next_s;
            arready_r <= (r_next_s == R_IDLE);
            rvalid_r  <= (r_next_s == R_DATA);
            if (ar_hs_s) begin
                rdata_r <= rd_data_s;
                rresp_r <= rd_resp_s;
            end
        end
    end

    axi_lite_reg_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_bank (
        .aclk     (aclk),
        .areset_n (areset_n),
        .we       (bank_we_s),
        .widx     (widx_s),
        .wdata    (commit_data_s),
        .wstrb    (commit_strb_s),
        .ridx     (ridx_s),
        .rdata    (bank_rdata_s)
    );

    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;
    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rdata   = rdata_r;
    assign rresp   = rresp_r;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_slave_regs
// Directed bench for axi_lite_slave_regs with hand-computed expectations.
// Honours AXI_LITE_SLAVE_ERR_EN for the out-of-range expectations.
// ---------------------------------------------------------------------------
module tb_axi_lite_slave_regs;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        aclk = 1'b0;
    logic        areset_n;
    logic [31:0] awaddr, wdata, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 aclk = ~aclk;

    axi_lite_slave_regs #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (16),
        .BASE_ADDR  (BASE)
    ) dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // AW and W in the same cycle, bready held high; checks B latency and response.
    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp);
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        tick();
        check({tag, "_bdone"}, 32'(bvalid), 32'd0);
    endtask

    // Single read with rready high; checks R latency, data and response.
    task automatic axi_read(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        check({tag, "_rdata"}, rdata, exp_data);
        check({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
        tick();
        check({tag, "_rdone"}, 32'(rvalid), 32'd0);
    endtask

    initial begin
        areset_n = 1'b0;
        awaddr = 32'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
        bready = 1'b0; araddr = 32'h0; arvalid = 1'b0; rready = 1'b0;

        // Reset held for two edges: every output low.
        tick();
        tick();
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        areset_n = 1'b1;
        tick();
        check("rel_awready", 32'(awready), 32'd1);
        check("rel_wready", 32'(wready), 32'd1);
        check("rel_arready", 32'(arready), 32'd1);

        // Full-word write then read back, plus low address bits ignored.
        axi_write("full_wr", BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, 2'b00);
        axi_read("full_rd", BASE + 32'h8, 32'hDEAD_BEEF, 2'b00);
        axi_read("lowbits_rd", BASE + 32'hA, 32'hDEAD_BEEF, 2'b00);

        // Partial strobe over an existing value.
        axi_write("pre_wr", BASE + 32'h4, 32'hAABB_CCDD, 4'hF, 2'b00);
        axi_write("part_wr", BASE + 32'h4, 32'h1122_3344, 4'b0101, 2'b00);
        axi_read("part_rd", BASE + 32'h4, 32'hAA22_CC44, 2'b00);
        axi_write("zero_strb_wr", BASE + 32'h4, 32'hFFFF_FFFF, 4'h0, 2'b00);
        axi_read("zero_strb_rd", BASE + 32'h4, 32'hAA22_CC44, 2'b00);

        // W arrives first; AW three cycles later, then B backpressure.
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        tick();
        wvalid = 1'b0;
        check("wfirst_wready", 32'(wready), 32'd0);
        check("wfirst_awready", 32'(awready), 32'd1);
        check("wfirst_bvalid", 32'(bvalid), 32'd0);
        araddr = BASE + 32'hC; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        check("precommit_rvalid", 32'(rvalid), 32'd1);
        check("precommit_rdata", rdata, 32'h0);
        check("precommit_wready", 32'(wready), 32'd0);
        tick();
        awaddr = BASE + 32'hC; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("late_aw_bvalid", 32'(bvalid), 32'd1);
        check("late_aw_bresp", 32'(bresp), 32'd0);
        awaddr = BASE; awvalid = 1'b1; wdata = 32'hFFFF_FFFF; wvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_bvalid", 32'(bvalid), 32'd1);
            check("bp_bresp", 32'(bresp), 32'd0);
            check("bp_awready", 32'(awready), 32'd0);
            check("bp_wready", 32'(wready), 32'd0);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        tick();
        check("bp_release_bvalid", 32'(bvalid), 32'd0);
        check("bp_release_awready", 32'(awready), 32'd1);
        check("bp_release_wready", 32'(wready), 32'd1);
        axi_read("late_aw_rd", BASE + 32'hC, 32'h1234_5678, 2'b00);
        axi_read("blocked_rd", BASE, 32'h0, 2'b00);

        // Read and write of the same register on the same edge.
        axi_write("same_pre_wr", BASE + 32'h18, 32'h0000_0001, 4'hF, 2'b00);
        awaddr = BASE + 32'h18; awvalid = 1'b1; wdata = 32'h0000_0002; wstrb = 4'hF; wvalid = 1'b1;
        araddr = BASE + 32'h18; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("same_rdata", rdata, 32'h0000_0001);
        check("same_bvalid", 32'(bvalid), 32'd1);
        tick();
        axi_read("same_post_rd", BASE + 32'h18, 32'h0000_0002, 2'b00);

        // Out-of-range access just past the bank.
        axi_write("reg0_wr", BASE, 32'h0BAD_F00D, 4'hF, 2'b00);
`ifdef AXI_LITE_SLAVE_ERR_EN
        axi_write("oor_wr", BASE + 32'h40, 32'h5A5A_5A5A, 4'hF, 2'b10);
        axi_read("oor_rd", BASE + 32'h40, 32'h0, 2'b10);
        axi_read("oor_reg0_rd", BASE, 32'h0BAD_F00D, 2'b00);
`else
        axi_write("oor_wr", BASE + 32'h40, 32'h5A5A_5A5A, 4'hF, 2'b00);
        axi_read("oor_rd", BASE + 32'h40, 32'h5A5A_5A5A, 2'b00);
        axi_read("oor_reg0_rd", BASE, 32'h5A5A_5A5A, 2'b00);
`endif

        // Reset after AW accepted but before W: transaction discarded.
        awaddr = BASE + 32'h14; awvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0;
        areset_n = 1'b0;
        tick();
        check("midrst_bvalid", 32'(bvalid), 32'd0);
        check("midrst_awready", 32'(awready), 32'd0);
        areset_n = 1'b1;
        tick();
        wdata = 32'h600D_CAFE; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("midrst_orphan_w_bvalid", 32'(bvalid), 32'd0);
        axi_read("midrst_reg5_rd", BASE + 32'h14, 32'h0, 2'b00);
        awaddr = BASE + 32'h14; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("fresh_bvalid", 32'(bvalid), 32'd1);
        check("fresh_bresp", 32'(bresp), 32'd0);
        tick();
        axi_read("fresh_rd", BASE + 32'h14, 32'h600D_CAFE, 2'b00);
        axi_read("cleared_reg2_rd", BASE + 32'h8, 32'h0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regs.md
# axi_lite_slave_regs

AXI4-Lite slave register bank that terminates the slave side of `axi_lite_if`. It consumes the read address, write address and write data channels and produces the read data and write response channels. It holds `NUM_REGS` 32-bit registers with byte-strobe writes. Read and write paths are independent, so the master's `start_read`/`start_write` transactions can overlap.

## Interface
- `ADDR_WIDTH`, 32: width of `awaddr`/`araddr`.
- `DATA_WIDTH`, 32: data width; strobe width is `DATA_WIDTH/8`.
- `NUM_REGS`, 16: register count; must be a power of two, ≥2.
- `BASE_ADDR`, 32'h0: byte address of register 0; must be word-aligned.
- `aclk` in 1: clock; all logic is on its rising edge.
- `areset_n` in 1: reset, synchronous, active-low.
- `awaddr` in ADDR_WIDTH, `awvalid` in 1, `awready` out 1: write address channel.
- `wdata` in DATA_WIDTH, `wstrb` in DATA_WIDTH/8, `wvalid` in 1, `wready` out 1: write data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.
- `araddr` in ADDR_WIDTH, `arvalid` in 1, `arready` out 1: read address channel.
- `rdata` out DATA_WIDTH, `rresp` out 2, `rvalid` out 1, `rready` in 1: read data channel.

## Operation
- **Decode**
  - `idx = (addr - BASE_ADDR) >> 2`.
  - `addr[1:0]` is ignored.
  - An address is in range when `BASE_ADDR ≤ addr < BASE_ADDR + 4*NUM_REGS`.
- **Write FSM states:** `W_IDLE`, `W_HAVE_A`, `W_HAVE_D`, `W_RESP`.
  - `W_IDLE`: `awready=wready=1`.
    - AW only → latch address, go to `W_HAVE_A`.
    - W only → latch data and strobe, go to `W_HAVE_D`.
    - Both in the same cycle → commit, go to `W_RESP`.
  - `W_HAVE_A`: `wready=1`, `awready=0`. W handshake → commit, go to `W_RESP`.
  - `W_HAVE_D`: `awready=1`, `wready=0`. AW handshake → commit, go to `W_RESP`.
  - `W_RESP`: `bvalid=1`, both readies 0. `bready` → `W_IDLE`.
- **Commit:** for each byte lane `i` with `wstrb[i]=1`, `reg[idx][8i+7:8i] <= wdata[8i+7:8i]`. Other lanes are unchanged. `wstrb=0` is a legal no-op and still returns OKAY.
- **Read FSM states:** `R_IDLE` (`arready=1`) and `R_DATA` (`rvalid=1`, `arready=0`).
  - AR handshake → `rdata=reg[idx]`, `rresp=OKAY`, go to `R_DATA`.
  - `rready` → `R_IDLE`.
- **Responses:** OKAY = 2'b00; SLVERR = 2'b10.
- **Same-edge read and write to one register:** the read returns the pre-write value.
- **Stability:** `rdata`, `rresp` and `bresp` are held stable while their valid is high and ready is low.

## Timing
- **Reset:** `areset_n=0` sampled at an edge gives, from that edge:
  - `awready=wready=arready=0`, `bvalid=rvalid=0`, `bresp=rresp=0`, `rdata=0`;
  - all registers 0;
  - both FSMs in IDLE.
- **After reset:** readies are registered. They rise at the first edge with `areset_n=1`, so they are 1 one cycle after reset release.
- **Reset mid-transaction:** held address/data and pending `bvalid`/`rvalid` are discarded without a response. A write not yet committed does not reach the registers.
- **Write latency:** the commit and `bvalid=1` happen at the edge where the later of AW/W completes. `bvalid` is visible the following cycle.
- **Read latency:** `rvalid` and `rdata` are registered at the AR handshake edge and visible the next cycle.
- **Throughput:** one transaction per channel pair per 2 cycles when the master holds `bready`/`rready` high.
- **Back-to-back:** B handshake at edge N → `awready`/`wready` high after edge N. R handshake behaves the same for `arready`.
- **Independence:** valids never depend combinationally on readies. No output depends combinationally on any input.

## Configuration
- `AXI_LITE_SLAVE_ERR_EN` defined:
  - Out-of-range write is dropped (no register change) and gets `bresp=SLVERR`.
  - Out-of-range read returns `rdata=0`, `rresp=SLVERR`.
  - Handshake timing is unchanged.
- Not defined:
  - `idx` uses the low `$clog2(NUM_REGS)` bits of `(addr-BASE_ADDR)>>2`, i.e. addresses alias modulo the bank size.
  - All responses are OKAY.

## Structure
- **Package `axi_lite_pkg`** holds `addr_t`, `data_t`, `strb_t`, `resp_t` and the constants `RESP_OKAY`, `RESP_SLVERR`. Both FSM state enums go there too.
- **Sub-module `axi_lite_reg_bank`:** storage array, strobe merge and synchronous clear. It has one write port (`we`, `widx`, `wdata`, `wstrb`) and one combinational read port (`ridx` → `rdata`).
- **Top level:** the FSMs and decode stay in `axi_lite_slave_regs`. Its ports bind one-to-one to the slave modport of `axi_lite_if`.

## Test plan
- **Reset:** hold `areset_n=0` 2 cycles → all outputs 0. One cycle after release, `awready=wready=arready=1`.
- **Full write/read:** write 0xDEADBEEF to BASE+0x8 with `wstrb=4'hF` (AW and W same cycle) → `bvalid` next cycle, `bresp=00`. Read BASE+0x8 → `rdata=0xDEADBEEF`, `rresp=00`.
- **Partial strobe:** write 0x11223344 with `wstrb=4'b0101` over a register holding 0xAABBCCDD → reads back 0xAA22CC44.
- **Channel order and backpressure:** W 3 cycles before AW → `wready=0` until B done, commit occurs only at the AW edge. Hold `bready=0` 4 cycles → `bvalid` and `bresp` stable, no new AW/W accepted.
- **Out of range:** write/read BASE+4*NUM_REGS.
  - With `AXI_LITE_SLAVE_ERR_EN`: SLVERR (10), `rdata=0`, reg0 unchanged.
  - Without: OKAY, the access hits reg0.
- **Reset mid-write:** AW accepted, assert reset before W → no `bvalid`, register unchanged (0). After release, a fresh write completes normally.
